// File: rtl/monitor_contagem.sv
// Sequence monitor for a 3-bit counter: checks hold/step-by-one, flags errors,
// pulses on wrap, keeps a saturating cycle count and drives a 7-seg digit.
`timescale 1ns/1ps
module monitor_contagem #(
  parameter bit UP         = 1'b1,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       resync,
  output logic [2:0] valor,
  output logic       travado,
  output logic       wrap,
  output logic [3:0] ciclos,
  output logic       erro,
  output logic [6:0] seg
);

  localparam int unsigned CW = 3;
  localparam int unsigned NW = 4;
  localparam logic [NW-1:0] CICLOS_MAX = '1;
  localparam logic [CW-1:0] WRAP_FROM  = UP ? CW'(7) : CW'(0);

  typedef enum logic [1:0] {SYNC, TRACK, ERRO} state_t;

  state_t        state;
  logic [CW-1:0] prev;
  logic [CW-1:0] next_val;
  logic          armed;

  assign next_val = UP ? prev + CW'(1) : prev - CW'(1);

  // Sample pipeline; armed keeps the reset-cleared sample out of the first check
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valor <= '0;
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      valor <= {in2, in1, in0};
      prev  <= valor;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= SYNC;
      travado <= 1'b0;
      wrap    <= 1'b0;
      ciclos  <= '0;
      erro    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (resync) begin
        state   <= SYNC;
        travado <= 1'b0;
        ciclos  <= '0;
        erro    <= 1'b0;
      end else begin
        case (state)
          SYNC: begin
            if (armed) begin
              state   <= TRACK;
              travado <= 1'b1;
            end
          end
          TRACK: begin
            if (valor != prev) begin
              if (valor == next_val) begin
                if (prev == WRAP_FROM) begin
                  wrap <= 1'b1;
                  if (ciclos != CICLOS_MAX) ciclos <= ciclos + NW'(1);
                end
              end else begin
                state   <= ERRO;
                erro    <= 1'b1;
                travado <= 1'b0;
              end
            end
          end
          ERRO: begin
            if (!ERR_STICKY) begin
              state <= SYNC;
              erro  <= 1'b0;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  // Active-high digit decode, seg[0]=a .. seg[6]=g
  always_comb begin
    seg = 7'b0111111;
    case (valor)
      3'd0: seg = 7'b0111111;
      3'd1: seg = 7'b0000110;
      3'd2: seg = 7'b1011011;
      3'd3: seg = 7'b1001111;
      3'd4: seg = 7'b1100110;
      3'd5: seg = 7'b1101101;
      3'd6: seg = 7'b1111101;
      3'd7: seg = 7'b0000111;
      default: seg = 7'b0111111;
    endcase
  end

endmodule

// File: tb/tb_monitor_contagem.sv
// Scoreboard bench: two monitors (UP/sticky and DOWN/non-sticky) driven by
// randomized counting streams and compared against a behavioural model.
`timescale 1ns/1ps
module tb_monitor_contagem;

  typedef struct packed {
    logic [2:0] valor;
    logic       travado;
    logic       wrap;
    logic [3:0] ciclos;
    logic       erro;
    logic [6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] din [2];
  logic       rs  [2];

  logic [2:0] valor0, valor1;
  logic       trav0, trav1, wrap0, wrap1, erro0, erro1;
  logic [3:0] cic0, cic1;
  logic [6:0] seg0, seg1;
  exp_t       act [2];

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  monitor_contagem #(.UP(1'b1), .ERR_STICKY(1'b1)) u_up (
    .clk(clk), .rstn(rstn), .in0(din[0][0]), .in1(din[0][1]), .in2(din[0][2]),
    .resync(rs[0]), .valor(valor0), .travado(trav0), .wrap(wrap0),
    .ciclos(cic0), .erro(erro0), .seg(seg0));

  monitor_contagem #(.UP(1'b0), .ERR_STICKY(1'b0)) u_dn (
    .clk(clk), .rstn(rstn), .in0(din[1][0]), .in1(din[1][1]), .in2(din[1][2]),
    .resync(rs[1]), .valor(valor1), .travado(trav1), .wrap(wrap1),
    .ciclos(cic1), .erro(erro1), .seg(seg1));

  always_comb begin
    act[0] = {valor0, trav0, wrap0, cic0, erro0, seg0};
    act[1] = {valor1, trav1, wrap1, cic1, erro1, seg1};
  end

  // Behavioural model state: sample history plus lock/error bookkeeping
  bit         m_up     [2] = '{1'b1, 1'b0};
  bit         m_sticky [2] = '{1'b1, 1'b0};
  logic [2:0] m_valor [2];
  logic [2:0] m_prev  [2];
  bit         m_track [2];
  bit         m_inerr [2];
  bit         m_wrap  [2];
  int         m_wait  [2];
  int         m_cic   [2];
  logic [2:0] cnt     [2];
  int         wraps   [2];

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    logic [6:0] tbl [8];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    return tbl[v];
  endfunction

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.valor   = m_valor[i];
    e.travado = m_track[i];
    e.wrap    = m_wrap[i];
    e.ciclos  = 4'(m_cic[i]);
    e.erro    = m_inerr[i];
    e.seg     = seg_of(m_valor[i]);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valor[i] = 3'd0; m_prev[i] = 3'd0;
      m_track[i] = 1'b0; m_inerr[i] = 1'b0; m_wrap[i] = 1'b0;
      m_wait[i]  = 2;    m_cic[i]   = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic [2:0] v, input bit r);
    int d;
    int step;
    m_wrap[i] = 1'b0;
    if (r) begin
      m_track[i] = 1'b0; m_inerr[i] = 1'b0; m_cic[i] = 0; m_wait[i] = 1;
    end else if (m_inerr[i]) begin
      if (!m_sticky[i]) begin
        m_inerr[i] = 1'b0; m_wait[i] = 1;
      end
    end else if (!m_track[i]) begin
      m_wait[i]--;
      if (m_wait[i] <= 0) m_track[i] = 1'b1;
    end else begin
      d    = (int'(m_valor[i]) - int'(m_prev[i]) + 8) % 8;
      step = m_up[i] ? 1 : 7;
      if (d == step) begin
        if (m_valor[i] == (m_up[i] ? 3'd0 : 3'd7)) begin
          m_wrap[i] = 1'b1;
          wraps[i]++;
          if (m_cic[i] < 15) m_cic[i]++;
        end
      end else if (d != 0) begin
        m_inerr[i] = 1'b1; m_track[i] = 1'b0;
      end
    end
    m_prev[i]  = m_valor[i];
    m_valor[i] = v;
    if (i == 0) q0.push_back(model_out(0));
    else        q1.push_back(model_out(1));
  endtask

  task automatic compare(input string nm, input int i, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst=%0d got valor=%0d trav=%b wrap=%b ciclos=%0d erro=%b seg=%h expected valor=%0d trav=%b wrap=%b ciclos=%0d erro=%b seg=%h",
               nm, i, a.valor, a.travado, a.wrap, a.ciclos, a.erro, a.seg,
               e.valor, e.travado, e.wrap, e.ciclos, e.erro, e.seg);
    end
  endtask

  // Monitor: one expected entry per active edge, checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare("edge", 0, act[0], e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare("edge", 1, act[1], e); end
    end
  end

  // kind: 0 step, 1 hold, 2 jump, 3 random mix; drives now, returns at next negedge
  task automatic cycle(input int kind, input bit r);
    int k;
    int p;
    for (int i = 0; i < 2; i++) begin
      k = kind;
      if (kind == 3) begin
        p = int'($urandom_range(99));
        k = (p < 75) ? 0 : (p < 90) ? 1 : 2;
      end
      if (k == 0)      cnt[i] = m_up[i] ? cnt[i] + 3'd1 : cnt[i] - 3'd1;
      else if (k == 2) cnt[i] = cnt[i] + 3'd3;
      din[i] = cnt[i];
      rs[i]  = r;
      model_edge(i, din[i], r);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    exp_t rst_e;
    rst_e = {3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 7'b0111111};
    for (int i = 0; i < 2; i++) compare(nm, i, act[i], rst_e);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin din[i] = 3'd0; rs[i] = 1'b0; wraps[i] = 0; end
    model_reset();
    @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    // Full count with wrap, then holds, then a jump and resync
    cnt[0] = 3'd0; cnt[1] = 3'd7;
    cycle(1, 1'b0);
    for (int n = 0; n < 8; n++) cycle(0, 1'b0);
    for (int n = 0; n < 4; n++) cycle(1, 1'b0);
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    cycle(2, 1'b0);
    for (int n = 0; n < 12; n++) cycle(0, 1'b0);
    cycle(0, 1'b1);
    for (int n = 0; n < 4; n++) cycle(0, 1'b0);

    // Count until six cycles are complete, then reset between edges
    for (int n = 0; n < 200 && !(m_cic[0] == 6 && m_valor[0] == 3'd5); n++) cycle(0, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset("async_reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) cycle(0, 1'b0);

    // Saturation: twenty full cycles
    for (int n = 0; n < 160; n++) cycle(0, 1'b0);

    // Randomized mix of steps, holds, jumps and resyncs
    for (int n = 0; n < 600; n++) cycle(3, $urandom_range(39) == 0);
    for (int n = 0; n < 3; n++) cycle(1, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got q0=%0d q1=%0d expected 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
